// File: rtl/hex_digit_bank.sv
// hex_digit_bank: N-digit hex/BCD register bank that drives active-low 7-segment displays.
// Each digit holds a 4-bit value and can be written through a valid/ready load port.
// On every prescaler tick the digits are held, rotated left, or counted up or down as BCD.
// digit_en only blanks the segment outputs; digit state keeps updating while blanked.
module hex_digit_bank #(
  parameter int N_DIGITS = 8,
  parameter int PRESCALE = 50000000,
  parameter int CNT_W    = 26,
  parameter int IDX_W    = 3
) (
  input  logic                    CLOCK_50,
  input  logic                    RESET,
  input  logic [1:0]              mode,
  input  logic [N_DIGITS-1:0]     digit_en,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [IDX_W-1:0]        load_idx,
  input  logic [3:0]              load_data,
  output logic                    tick,
  output logic                    wrap,
  output logic [4*N_DIGITS-1:0]   digits,
  output logic [7*N_DIGITS-1:0]   hex
);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_ROT  = 2'b01;
  localparam logic [1:0] MODE_UP   = 2'b10;
  localparam logic [1:0] MODE_DN   = 2'b11;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [6:0]       SEG_OFF  = 7'h7F;

  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;
  logic             r_wrap;
  logic [3:0]       r_dig [N_DIGITS];

  logic [3:0]       w_rot [N_DIGITS];
  logic [3:0]       w_up  [N_DIGITS];
  logic [3:0]       w_dn  [N_DIGITS];
  logic [3:0]       w_nxt [N_DIGITS];
  logic             w_up_co;
  logic             w_dn_bo;
  logic             w_update;
  logic             w_wrap_nxt;

  // Active-low {g..a} segment pattern for one hex value.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    s = SEG_OFF;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

  // Prescaler: free-running 0..PRESCALE-1 counter, tick registered on the wrap.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + CNT_W'(1);
      r_tick <= 1'b0;
    end
  end

  // A tick in a non-hold mode owns the digit registers for that cycle.
  assign w_update   = r_tick & (mode != MODE_HOLD);
  assign load_ready = ~w_update;

  // Rotate left: each digit takes its lower neighbour, digit 0 takes the top digit.
  always_comb begin
    for (int i = 0; i < N_DIGITS; i++) begin
      w_rot[i] = r_dig[(i + N_DIGITS - 1) % N_DIGITS];
    end
  end

  // BCD increment ripple; out-of-range digits with carry-in normalise to 0.
  always_comb begin : p_up
    logic w_c;
    w_c = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      w_up[i] = r_dig[i];
      if (w_c) begin
        if (r_dig[i] >= 4'd9) begin
          w_up[i] = 4'd0;
        end else begin
          w_up[i] = r_dig[i] + 4'd1;
          w_c     = 1'b0;
        end
      end
    end
    w_up_co = w_c;
  end

  // BCD decrement ripple; out-of-range digits with borrow-in clamp to 9 and stop the borrow.
  always_comb begin : p_dn
    logic w_b;
    w_b = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      w_dn[i] = r_dig[i];
      if (w_b) begin
        if (r_dig[i] == 4'd0) begin
          w_dn[i] = 4'd9;
        end else if (r_dig[i] > 4'd9) begin
          w_dn[i] = 4'd9;
          w_b     = 1'b0;
        end else begin
          w_dn[i] = r_dig[i] - 4'd1;
          w_b     = 1'b0;
        end
      end
    end
    w_dn_bo = w_b;
  end

  // Next digit values: tick update first, otherwise an accepted in-range load.
  always_comb begin
    for (int i = 0; i < N_DIGITS; i++) begin
      w_nxt[i] = r_dig[i];
    end
    if (w_update) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        case (mode)
          MODE_ROT: w_nxt[i] = w_rot[i];
          MODE_UP:  w_nxt[i] = w_up[i];
          MODE_DN:  w_nxt[i] = w_dn[i];
          default:  w_nxt[i] = r_dig[i];
        endcase
      end
    end else if (load_valid) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        if (32'(load_idx) == 32'(i)) begin
          w_nxt[i] = load_data;
        end
      end
    end
  end

  // wrap flags a carry or borrow leaving the most significant digit.
  always_comb begin
    w_wrap_nxt = 1'b0;
    if (r_tick) begin
      if (mode == MODE_UP) begin
        w_wrap_nxt = w_up_co;
      end else if (mode == MODE_DN) begin
        w_wrap_nxt = w_dn_bo;
      end
    end
  end

  // Digit and wrap registers.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        r_dig[i] <= 4'd0;
      end
      r_wrap <= 1'b0;
    end else begin
      for (int i = 0; i < N_DIGITS; i++) begin
        r_dig[i] <= w_nxt[i];
      end
      r_wrap <= w_wrap_nxt;
    end
  end

  assign tick = r_tick;
  assign wrap = r_wrap;

  // Flatten raw digits and decode segments, blanking disabled digits.
  always_comb begin
    digits = '0;
    hex    = '1;
    for (int i = 0; i < N_DIGITS; i++) begin
      digits[4*i +: 4] = r_dig[i];
      hex[7*i +: 7]    = digit_en[i] ? seg7(r_dig[i]) : SEG_OFF;
    end
  end

endmodule

// File: tb/tb_hex_digit_bank.sv
// Directed bench for hex_digit_bank with a 4-digit bank and a 4-cycle prescaler.
module tb_hex_digit_bank;

  localparam int N  = 4;
  localparam int PS = 4;

  logic          CLOCK_50 = 1'b0;
  logic          RESET;
  logic [1:0]    mode;
  logic [N-1:0]  digit_en;
  logic          load_valid;
  logic          load_ready;
  logic [2:0]    load_idx;
  logic [3:0]    load_data;
  logic          tick;
  logic          wrap;
  logic [4*N-1:0] digits;
  logic [7*N-1:0] hex;

  int n_assert = 0;
  int n_fail   = 0;

  hex_digit_bank #(
    .N_DIGITS (N),
    .PRESCALE (PS),
    .CNT_W    (2),
    .IDX_W    (3)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .RESET      (RESET),
    .mode       (mode),
    .digit_en   (digit_en),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_idx   (load_idx),
    .load_data  (load_data),
    .tick       (tick),
    .wrap       (wrap),
    .digits     (digits),
    .hex        (hex)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next negedge where tick is high, bounded.
  task automatic wait_tick(input string tag);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 4 * PS; k++) begin
      @(negedge CLOCK_50);
      if (tick) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  task automatic load1(input logic [2:0] idx, input logic [3:0] data);
    load_valid = 1'b1;
    load_idx   = idx;
    load_data  = data;
    @(negedge CLOCK_50);
    load_valid = 1'b0;
  endtask

  logic [15:0] rot_exp [4];

  initial begin
    rot_exp[0] = 16'h3214;
    rot_exp[1] = 16'h2143;
    rot_exp[2] = 16'h1432;
    rot_exp[3] = 16'h4321;

    RESET      = 1'b1;
    mode       = 2'b00;
    digit_en   = 4'hF;
    load_valid = 1'b0;
    load_idx   = 3'd0;
    load_data  = 4'd0;

    // Reset state
    #1;
    chk("rst_digits", 32'(digits), 32'h0);
    chk("rst_hex", 32'(hex), 32'({7'h40, 7'h40, 7'h40, 7'h40}));
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_wrap", 32'(wrap), 32'd0);
    chk("rst_ready", 32'(load_ready), 32'd1);
    repeat (2) @(negedge CLOCK_50);
    RESET = 1'b0;

    // Free run: tick every 4th cycle after release
    for (int k = 1; k <= 12; k++) begin
      @(negedge CLOCK_50);
      chk($sformatf("tick_c%0d", k), 32'(tick), 32'((k % PS) == 0));
    end
    chk("run_digits", 32'(digits), 32'h0);
    chk("run_hex0", 32'(hex[6:0]), 32'(7'b1000000));
    chk("run_wrap", 32'(wrap), 32'd0);

    // Hold mode loads
    load1(3'd0, 4'd1);
    load1(3'd1, 4'd2);
    load1(3'd2, 4'd3);
    load1(3'd3, 4'd4);
    chk("load_digits", 32'(digits), 32'h4321);
    chk("load_hex0", 32'(hex[6:0]), 32'(7'b1111001));
    chk("load_hex", 32'(hex), 32'({7'h19, 7'h30, 7'h24, 7'h79}));
    chk("load_ready_hold", 32'(load_ready), 32'd1);
    load1(3'd5, 4'd7);
    chk("load_oob", 32'(digits), 32'h4321);

    // Rotate left
    wait_tick("sync_rot");
    @(negedge CLOCK_50);
    mode = 2'b01;
    for (int j = 0; j < 4; j++) begin
      wait_tick($sformatf("rot_tick%0d", j));
      chk($sformatf("rot_ready%0d", j), 32'(load_ready), 32'd0);
      @(negedge CLOCK_50);
      chk($sformatf("rot%0d", j), 32'(digits), 32'(rot_exp[j]));
    end

    // BCD up with all-digit wrap
    mode = 2'b00;
    wait_tick("sync_up");
    @(negedge CLOCK_50);
    load1(3'd0, 4'd8);
    load1(3'd1, 4'd9);
    load1(3'd2, 4'd9);
    load1(3'd3, 4'd9);
    chk("up_load", 32'(digits), 32'h9998);
    wait_tick("sync_up2");
    @(negedge CLOCK_50);
    mode = 2'b10;
    wait_tick("up_tick1");
    @(negedge CLOCK_50);
    chk("up1_digits", 32'(digits), 32'h9999);
    chk("up1_wrap", 32'(wrap), 32'd0);
    wait_tick("up_tick2");
    @(negedge CLOCK_50);
    chk("up2_digits", 32'(digits), 32'h0000);
    chk("up2_wrap", 32'(wrap), 32'd1);
    @(negedge CLOCK_50);
    chk("up2_wrap_off", 32'(wrap), 32'd0);

    // BCD down with wrap, then an out-of-range digit
    mode = 2'b11;
    wait_tick("dn_tick1");
    @(negedge CLOCK_50);
    chk("dn1_digits", 32'(digits), 32'h9999);
    chk("dn1_wrap", 32'(wrap), 32'd1);
    load1(3'd0, 4'hF);
    chk("dn_loadF", 32'(digits), 32'h999F);
    wait_tick("dn_tick2");
    @(negedge CLOCK_50);
    chk("dn2_digits", 32'(digits), 32'h9999);
    chk("dn2_wrap", 32'(wrap), 32'd0);

    // Load colliding with a counting tick
    mode = 2'b10;
    wait_tick("col_tick");
    load_valid = 1'b1;
    load_idx   = 3'd1;
    load_data  = 4'd5;
    chk("col_ready0", 32'(load_ready), 32'd0);
    @(negedge CLOCK_50);
    chk("col_digits_tick", 32'(digits), 32'h0000);
    chk("col_wrap", 32'(wrap), 32'd1);
    chk("col_ready1", 32'(load_ready), 32'd1);
    @(negedge CLOCK_50);
    load_valid = 1'b0;
    chk("col_landed", 32'(digits), 32'h0050);

    // Blanking leaves digit state counting
    digit_en = 4'b0101;
    #1;
    chk("blank_hex", 32'(hex), 32'({7'h7F, 7'h40, 7'h7F, 7'h40}));
    wait_tick("blank_tick");
    @(negedge CLOCK_50);
    chk("blank_digits", 32'(digits), 32'h0051);
    chk("blank_hex2", 32'(hex), 32'({7'h7F, 7'h40, 7'h7F, 7'h79}));

    // Asynchronous reset between clock edges
    @(negedge CLOCK_50);
    #2;
    RESET = 1'b1;
    #1;
    chk("arst_digits", 32'(digits), 32'h0);
    chk("arst_tick", 32'(tick), 32'd0);
    chk("arst_wrap", 32'(wrap), 32'd0);
    chk("arst_ready", 32'(load_ready), 32'd1);
    chk("arst_hex", 32'(hex), 32'({7'h7F, 7'h40, 7'h7F, 7'h40}));
    @(negedge CLOCK_50);
    RESET    = 1'b0;
    digit_en = 4'hF;
    for (int k = 1; k <= 4; k++) begin
      @(negedge CLOCK_50);
      chk($sformatf("rst2_tick_c%0d", k), 32'(tick), 32'(k == PS));
    end
    chk("rst2_digits", 32'(digits), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
